// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, parallel load, optional rotate, and a load-then-shift burst.
// Define UNIV_SHIFT_REG_ROTATE_EN to enable rotate modes 100/101; without it those modes hold.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [CNT_W-1:0] nbits,
  output logic [WIDTH-1:0] pout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] burst_len;

  // Out-of-range counts (zero or longer than the register) mean a full-width burst.
  assign burst_len = ((nbits == '0) || (nbits > FULL_CNT)) ? FULL_CNT : nbits;

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    if (en) begin
      done_d = 1'b0;
      if (busy_q) begin
        q_d   = {q_q[WIDTH-2:0], sin_l};
        cnt_d = cnt_q - ONE_CNT;
        if (cnt_q == ONE_CNT) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else if (start) begin
        q_d    = pin;
        cnt_d  = burst_len;
        busy_d = 1'b1;
      end else begin
        case (mode)
          3'b001:  q_d = {q_q[WIDTH-2:0], sin_l};
          3'b010:  q_d = {sin_r, q_q[WIDTH-1:1]};
          3'b011:  q_d = pin;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
          3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
          3'b100,
          3'b101:  q_d = q_q;
`endif
          default: q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign pout   = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, 8, register length in bits; SHALL be at least 2.
REQ-002 Parameter: CNT_W, $clog2(WIDTH+1), width of nbits and the internal burst counter.
REQ-003 Port: clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  global enable; when low, all state SHALL hold.
REQ-006 Port: mode  input  3  operation select for manual (non-burst) cycles.
REQ-007 Port: sin_l  input  1  serial data entering bit 0 on every left shift.
REQ-008 Port: sin_r  input  1  serial data entering bit WIDTH-1 on every right shift.
REQ-009 Port: pin  input  WIDTH  parallel load data.
REQ-010 Port: start  input  1  burst request: load pin, then shift left nbits times.
REQ-011 Port: nbits  input  CNT_W  burst shift count.
REQ-012 Port: pout  output  WIDTH  register contents q.
REQ-013 Port: sout_l  output  1  q[WIDTH-1].
REQ-014 Port: sout_r  output  1  q[0].
REQ-015 Port: busy  output  1  high while a burst is in progress.
REQ-016 Port: done  output  1  one-cycle pulse when a burst completes.

Function
REQ-017 Outputs pout, sout_l and sout_r SHALL be driven combinationally from registered q.
REQ-018 Manual mode decode (en=1, busy=0, no start): 000 hold; 001 q<={q[W-2:0],sin_l}; 010 q<={sin_r,q[W-1:1]}; 011 q<=pin; 100 rotate left; 101 rotate right; 110 and 111 hold.
REQ-019 Burst accept: an edge with en=1, busy=0, start=1 SHALL set q<=pin, cnt<=N and busy<=1; mode SHALL be ignored on that edge.
REQ-020 N SHALL equal nbits, except that nbits=0 or nbits>WIDTH SHALL give N=WIDTH.
REQ-021 Burst shifting: each edge with en=1 and busy=1 SHALL do q<={q[W-2:0],sin_l} and cnt<=cnt-1.
REQ-022 The edge that takes cnt from 1 to 0 SHALL clear busy and set done.
REQ-023 done SHALL be high for exactly one cycle and SHALL then clear.
REQ-024 A burst SHALL therefore take 1 load cycle plus N shift cycles.
REQ-025 While busy=1, mode and start SHALL be ignored; a start held high through completion SHALL NOT retrigger on the edge that clears busy.
REQ-026 A new start SHALL be accepted on the first edge where busy=0 has been observed.
REQ-027 While en=0, q, cnt, busy and done SHALL all hold; a pending done SHALL stay high until the next enabled edge.
REQ-028 start asserted while en=0 SHALL be ignored.

Reset
REQ-029 While reset=0: q=0, cnt=0, busy=0, done=0, immediately and without waiting for clk.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-031 The first edge after reset deasserts SHALL be a normal operating edge.

Configuration
REQ-032 Macro UNIV_SHIFT_REG_ROTATE_EN defined: modes 100 and 101 SHALL rotate, q<={q[W-2:0],q[W-1]} and q<={q[0],q[W-1:1]} respectively.
REQ-033 Macro UNIV_SHIFT_REG_ROTATE_EN undefined: modes 100 and 101 SHALL hold q, and no rotate logic SHALL be synthesised.

Verification (WIDTH=8)
REQ-034 Manual left shift: from reset, mode=001 with sin_l=1,0,1,1 on 4 edges -> pout=8'h0B, sout_l=0.
REQ-035 Load and rotate: mode=011 with pin=8'hA5, then mode=100 for one edge -> pout=8'h4B; then mode=101 -> pout=8'hA5; with the macro undefined, pout SHALL stay 8'hA5 throughout.
REQ-036 Manual right shift: mode=010, sin_r=1, 8 edges from q=0 -> pout=8'hFF; sout_r SHALL rise on the 8th edge.
REQ-037 Burst: pin=8'hC3, nbits=3, sin_l=0, start for one edge -> busy high for 3 cycles; sout_l=1,1,0,0 after each successive edge; done pulses once; final pout=8'h18.
REQ-038 Burst edge cases:
- en low for 2 cycles mid-burst -> busy stretches by exactly 2 cycles, same final pout.
- nbits=0 -> exactly 8 shifts.
REQ-039 Reset asserted after the 2nd burst shift -> pout=0 and busy=0 immediately; done never asserts.
